// File: rtl/decode_regfile_if.sv
// Bus between fetch/write-back and the decode stage: instruction and write-back value in,
// operands, immediates, control strobes and status out.
interface decode_regfile_if #(
    parameter int XLEN = 64
);
    logic [31:0]     inst;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] t3;
    logic            sel;
    logic [3:0]      alu_ctrl;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            illegal;
    logic [63:0]     retired;

    modport master (
        output inst, wr_data,
        input  rs1_data, rs2_data, imm, t3, sel, alu_ctrl, alu_src,
               reg_write, mem_read, mem_write, mem_to_reg, illegal, retired
    );

    modport slave (
        input  inst, wr_data,
        output rs1_data, rs2_data, imm, t3, sel, alu_ctrl, alu_src,
               reg_write, mem_read, mem_write, mem_to_reg, illegal, retired
    );
endinterface

// File: rtl/decode_regfile.sv
// Single-cycle RISC-V decode stage: instruction decode, 32 x XLEN register file,
// branch resolution, sticky illegal-instruction flag and retired-instruction counter.
module decode_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic             clk_i,
    input  logic             start_i,
    decode_regfile_if.slave  bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LD     = 7'b0000011;
    localparam logic [6:0] OP_SD     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;

    logic [XLEN-1:0] regs_q [NREGS];
    logic            illegal_q, illegal_d;
    logic [63:0]     retired_q, retired_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1Idx, rs2Idx, rdIdx;
    logic [XLEN-1:0] immI, immS, immB;
    logic [XLEN-1:0] rs1Val, rs2Val;

    logic            legal;
    logic            isBranch;
    logic            branchCond;
    logic [3:0]      aluCtrl;
    logic            aluSrc, regWrite, memRead, memWrite, memToReg;
    logic [XLEN-1:0] immOut, t3Out;

    assign opcode = bus.inst[6:0];
    assign funct3 = bus.inst[14:12];
    assign funct7 = bus.inst[31:25];
    assign rs1Idx = bus.inst[19:15];
    assign rs2Idx = bus.inst[24:20];
    assign rdIdx  = bus.inst[11:7];

    assign immI = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
    assign immS = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
    assign immB = {{(XLEN-13){bus.inst[31]}}, bus.inst[31], bus.inst[7],
                   bus.inst[30:25], bus.inst[11:8], 1'b0};

    // x0 reads as zero regardless of what the array holds
    assign rs1Val = (rs1Idx == 5'd0) ? '0 : regs_q[rs1Idx];
    assign rs2Val = (rs2Idx == 5'd0) ? '0 : regs_q[rs2Idx];

    always_comb begin
        legal    = 1'b0;
        isBranch = 1'b0;
        aluCtrl  = ALU_ADD;
        aluSrc   = 1'b0;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memToReg = 1'b0;
        immOut   = '0;
        t3Out    = '0;

        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  aluCtrl = ALU_ADD;
                        3'b001:  aluCtrl = ALU_SLL;
                        3'b010:  aluCtrl = ALU_SLT;
                        3'b011:  aluCtrl = ALU_SLTU;
                        3'b100:  aluCtrl = ALU_XOR;
                        3'b101:  aluCtrl = ALU_SRL;
                        3'b110:  aluCtrl = ALU_OR;
                        default: aluCtrl = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        legal   = 1'b1;
                        aluCtrl = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        legal   = 1'b1;
                        aluCtrl = ALU_SRA;
                    end
                end
                regWrite = 1'b1;
            end
            OP_I: begin
                legal = 1'b1;
                case (funct3)
                    3'b000: aluCtrl = ALU_ADD;
                    3'b010: aluCtrl = ALU_SLT;
                    3'b011: aluCtrl = ALU_SLTU;
                    3'b100: aluCtrl = ALU_XOR;
                    3'b110: aluCtrl = ALU_OR;
                    3'b111: aluCtrl = ALU_AND;
                    3'b001: begin
                        aluCtrl = ALU_SLL;
                        legal   = (bus.inst[31:26] == 6'b000000);
                    end
                    default: begin
                        // shamt is six bits, so bit 30 alone separates SRAI from SRLI
                        if (bus.inst[31:26] == 6'b000000) begin
                            aluCtrl = ALU_SRL;
                        end else if (bus.inst[31:26] == 6'b010000) begin
                            aluCtrl = ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                endcase
                aluSrc   = 1'b1;
                regWrite = 1'b1;
                immOut   = immI;
            end
            OP_LD: begin
                legal    = (funct3 == 3'b011);
                aluSrc   = 1'b1;
                regWrite = 1'b1;
                memRead  = 1'b1;
                memToReg = 1'b1;
                immOut   = immI;
            end
            OP_SD: begin
                legal    = (funct3 == 3'b011);
                aluSrc   = 1'b1;
                memWrite = 1'b1;
                immOut   = immS;
            end
            OP_BRANCH: begin
                legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
                isBranch = 1'b1;
                aluCtrl  = ALU_SUB;
                t3Out    = immB;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            isBranch = 1'b0;
            aluCtrl  = ALU_ADD;
            aluSrc   = 1'b0;
            regWrite = 1'b0;
            memRead  = 1'b0;
            memWrite = 1'b0;
            memToReg = 1'b0;
            immOut   = '0;
            t3Out    = '0;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  branchCond = (rs1Val == rs2Val);
            3'b001:  branchCond = (rs1Val != rs2Val);
            3'b100:  branchCond = ($signed(rs1Val) <  $signed(rs2Val));
            3'b101:  branchCond = ($signed(rs1Val) >= $signed(rs2Val));
            3'b110:  branchCond = (rs1Val <  rs2Val);
            3'b111:  branchCond = (rs1Val >= rs2Val);
            default: branchCond = 1'b0;
        endcase
    end

    always_comb begin
        illegal_d = illegal_q | ~legal;
        retired_d = legal ? retired_q + 64'd1 : retired_q;
    end

    // Reset clears everything immediately, so a write on a coincident edge is dropped
    always_ff @(posedge clk_i or posedge start_i) begin
        if (start_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (regWrite && (rdIdx != 5'd0)) begin
                regs_q[rdIdx] <= bus.wr_data;
            end
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign bus.rs1_data   = rs1Val;
    assign bus.rs2_data   = rs2Val;
    assign bus.imm        = immOut;
    assign bus.t3         = t3Out;
    assign bus.sel        = isBranch & branchCond;
    assign bus.alu_ctrl   = aluCtrl;
    assign bus.alu_src    = aluSrc;
    assign bus.reg_write  = regWrite;
    assign bus.mem_read   = memRead;
    assign bus.mem_write  = memWrite;
    assign bus.mem_to_reg = memToReg;
    assign bus.illegal    = illegal_q;
    assign bus.retired    = retired_q;

endmodule
